// File: rtl/mc_pkg.sv
// Shared definitions for the WISC multicycle sequencer: state encodings,
// opcode constants and the instruction class used by the decode logic.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU  = 3'd0,
        CLS_LD   = 3'd1,
        CLS_ST   = 3'd2,
        CLS_STU  = 3'd3,
        CLS_BR   = 3'd4,
        CLS_LINK = 3'd5,
        CLS_NOP  = 3'd6,
        CLS_ILL  = 3'd7
    } cls_t;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_ILL  = 5'b00010;
    localparam logic [4:0] OP_NOP2 = 5'b00011;
    localparam logic [4:0] OP_ST   = 5'b10000;
    localparam logic [4:0] OP_LD   = 5'b10001;
    localparam logic [4:0] OP_STU  = 5'b10011;

endpackage

// File: rtl/op_classify.sv
// Opcode to instruction-class decoder. Purely combinational so the pipelined
// hazard unit can reuse it. HALT has no class of its own: it decodes as
// CLS_ILL and the sequencer tests OP_HALT ahead of the class.
module op_classify
    import mc_pkg::*;
(
    input  logic [4:0] opcode,
    output logic [2:0] cls
);

    cls_t cls_e;

    // Map each opcode group onto its execution class.
    always_comb begin
        cls_e = CLS_ILL;
        casez (opcode)
            OP_NOP, OP_NOP2:                  cls_e = CLS_NOP;
            5'b0010?, 5'b011??:               cls_e = CLS_BR;
            5'b0011?:                         cls_e = CLS_LINK;
            5'b010??, 5'b10010, 5'b101??,
            5'b11???:                         cls_e = CLS_ALU;
            OP_LD:                            cls_e = CLS_LD;
            OP_ST:                            cls_e = CLS_ST;
            OP_STU:                           cls_e = CLS_STU;
            default:                          cls_e = CLS_ILL;
        endcase
    end

    assign cls = cls_e;

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multicycle sequencing controller: steps the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB, with memory wait-state timeout, HALT/illegal
// trapping and a retired-instruction counter.
//
// state   | meaning
// FETCH   | imem request, load IR when memory ready
// DECODE  | classify opcode; NOP retires here, HALT/ILL trap
// EXEC    | one ALU cycle; branches retire here
// MEM     | data memory access, waits on mem_rdy
// WB      | register-file write and PC update
// HALT_ST | stopped; only reset leaves
module mc_seq_ctrl
    import mc_pkg::*;
#(
    parameter int TMO_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       opcode,
    input  logic             mem_rdy,
    output logic             imem_en,
    output logic             ir_ld,
    output logic             dmem_en,
    output logic             dmem_wr,
    output logic             rf_we,
    output logic             pc_ld,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    // The terminal step is the wait cycle that takes the counter to all-ones.
    localparam logic [TMO_W-1:0] TMO_PRE = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t           state_q, state_d;
    cls_t             cls_q, cls_dec;
    logic [2:0]       cls_raw;
    logic [TMO_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] retired_q;
    logic             err_q;
    logic             is_halt, waiting, tmo_tc;

    op_classify u_op_classify (
        .opcode (opcode),
        .cls    (cls_raw)
    );

    assign cls_dec = cls_t'(cls_raw);
    assign is_halt = (opcode == OP_HALT);
    assign waiting = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_rdy;
    assign tmo_tc  = waiting && (tmo_cnt == TMO_PRE);

    // State register and decoded class.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cls_q   <= CLS_NOP;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE)
                cls_q <= cls_dec;
        end
    end

    // Next-state logic; a completing access takes priority over timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_rdy)     state_d = ST_DECODE;
                else if (tmo_tc) state_d = ST_HALT;
            end
            ST_DECODE: begin
                if (is_halt || cls_dec == CLS_ILL) state_d = ST_HALT;
                else if (cls_dec == CLS_NOP)       state_d = ST_FETCH;
                else                               state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_LD, CLS_ST, CLS_STU: state_d = ST_MEM;
                    CLS_ALU, CLS_LINK:       state_d = ST_WB;
                    default:                 state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_rdy)     state_d = (cls_q == CLS_ST) ? ST_FETCH : ST_WB;
                else if (tmo_tc) state_d = ST_HALT;
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // Datapath enables; forced low while reset is held so an access aborts at once.
    always_comb begin
        imem_en = 1'b0;
        ir_ld   = 1'b0;
        dmem_en = 1'b0;
        dmem_wr = 1'b0;
        rf_we   = 1'b0;
        pc_ld   = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    imem_en = 1'b1;
                    ir_ld   = mem_rdy;
                end
                ST_DECODE: pc_ld = !is_halt && (cls_dec == CLS_NOP);
                ST_EXEC:   pc_ld = (cls_q == CLS_BR);
                ST_MEM: begin
                    dmem_en = 1'b1;
                    dmem_wr = (cls_q == CLS_ST) || (cls_q == CLS_STU);
                    pc_ld   = mem_rdy && (cls_q == CLS_ST);
                end
                ST_WB: begin
                    rf_we = 1'b1;
                    pc_ld = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Wait-state counter: cleared on entry to FETCH or MEM, counts stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if ((state_d != state_q) && (state_d == ST_FETCH || state_d == ST_MEM))
            tmo_cnt <= '0;
        else if (waiting)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Sticky fault flag: any trap into HALT_ST other than a HALT instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (state_d == ST_HALT && state_q != ST_HALT &&
                 !(state_q == ST_DECODE && is_halt))
            err_q <= 1'b1;
    end

    // Retired count advances on the single PC update of each instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retired_q <= '0;
        else if (pc_ld)
            retired_q <= retired_q + 1'b1;
    end

    assign halted  = (state_q == ST_HALT);
    assign err     = err_q;
    assign retired = retired_q;
    assign state   = state_q;

endmodule
